pll_retune_ctrl: RTL and testbench

//  Avalon-MM master that retunes the processor PLL at run time. It takes one request

---
 rtl/pll_retune_ctrl.sv | 176 +++++++++++++++++
 tb/tb_pll_retune_ctrl.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_retune_ctrl.sv
// PLL run-time retune controller: Avalon-MM master that programs the
// reconfiguration core (mode, N, M, C, start), then waits for re-lock.
module pll_retune_ctrl #(
    parameter int C_INDEX     = 0,
    parameter int TIMEOUT_CYC = 65536,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [7:0]  req_n_hi,
    input  logic [7:0]  req_n_lo,
    input  logic [7:0]  req_m_hi,
    input  logic [7:0]  req_m_lo,
    input  logic [7:0]  req_c_hi,
    input  logic [7:0]  req_c_lo,
    input  logic        req_n_odd,
    input  logic        req_m_odd,
    input  logic        req_c_odd,
    output logic [5:0]  mgmt_address,
    output logic        mgmt_write,
    output logic [31:0] mgmt_writedata,
    input  logic        mgmt_waitrequest,
    input  logic        pll_locked,
    output logic        busy,
    output logic        done,
    output logic [1:0]  err_code
);

    localparam int TW = $clog2(TIMEOUT_CYC);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYC - 1);
    // Lock is only trusted after the deassert latency plus a full
    // synchroniser flush, so a stale "locked" is never sampled.
    localparam logic [TW-1:0] T_IGN = TW'(2 + SYNC_STAGES);
    localparam logic [4:0] CIDX = 5'(C_INDEX);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_MODE,
        S_WR_N,
        S_WR_M,
        S_WR_C,
        S_WR_START,
        S_WAIT_LOCK,
        S_FIN
    } state_t;

    state_t                 state_q, state_d;
    logic [TW-1:0]          timer_q, timer_d;
    logic [1:0]             err_q, err_d;
    logic [31:0]            n_word_q, m_word_q, c_word_q;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   locked_s;
    logic                   in_write;
    logic                   accept;

    function automatic logic [31:0] cnt_word(input logic [7:0] hi,
                                             input logic [7:0] lo,
                                             input logic       odd);
        cnt_word = {14'b0, odd, (hi == 8'd0 && lo == 8'd0), hi, lo};
    endfunction

    assign in_write = (state_q == S_WR_MODE) || (state_q == S_WR_N) ||
                      (state_q == S_WR_M) || (state_q == S_WR_C) ||
                      (state_q == S_WR_START);
    assign accept   = (state_q == S_IDLE) && req_valid;
    assign locked_s = sync_q[SYNC_STAGES-1];

    // Bring the asynchronous lock indication into the clk domain
    always_ff @(posedge clk or posedge rst) begin
        if (rst) sync_q <= '0;
        else     sync_q <= {sync_q[SYNC_STAGES-2:0], pll_locked};
    end

    // State, per-state timer and sticky error code
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            timer_q <= '0;
            err_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            err_q   <= err_d;
        end
    end

    // Capture the divider words once, at acceptance
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            n_word_q <= '0;
            m_word_q <= '0;
            c_word_q <= '0;
        end else if (accept) begin
            n_word_q <= cnt_word(req_n_hi, req_n_lo, req_n_odd);
            m_word_q <= cnt_word(req_m_hi, req_m_lo, req_m_odd);
            c_word_q <= cnt_word(req_c_hi, req_c_lo, req_c_odd) |
                        {9'b0, CIDX, 18'b0};
        end
    end

    // Next state: walk the write list, then wait for lock or time out
    always_comb begin
        state_d = state_q;
        err_d   = err_q;
        unique case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    state_d = S_WR_MODE;
                    err_d   = 2'd0;
                end
            end
            S_WR_MODE:  if (!mgmt_waitrequest) state_d = S_WR_N;
            S_WR_N:     if (!mgmt_waitrequest) state_d = S_WR_M;
            S_WR_M:     if (!mgmt_waitrequest) state_d = S_WR_C;
            S_WR_C:     if (!mgmt_waitrequest) state_d = S_WR_START;
            S_WR_START: if (!mgmt_waitrequest) state_d = S_WAIT_LOCK;
            S_WAIT_LOCK: begin
                if (timer_q >= T_IGN && locked_s) begin
                    state_d = S_FIN;
                    err_d   = 2'd0;
                end else if (timer_q == T_LAST) begin
                    state_d = S_FIN;
                    err_d   = 2'd2;
                end
            end
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (in_write && mgmt_waitrequest && timer_q == T_LAST) begin
            state_d = S_FIN;
            err_d   = 2'd1;
        end
        if (state_d != state_q)
            timer_d = '0;
        else if (in_write || state_q == S_WAIT_LOCK)
            timer_d = timer_q + 1'b1;
        else
            timer_d = '0;
    end

    // Outputs decoded from the registered state and captured words
    always_comb begin
        mgmt_write     = in_write;
        mgmt_address   = 6'd0;
        mgmt_writedata = 32'd0;
        req_ready      = (state_q == S_IDLE);
        busy           = in_write || (state_q == S_WAIT_LOCK);
        done           = (state_q == S_FIN);
        err_code       = err_q;
        unique case (state_q)
            S_WR_N: begin
                mgmt_address   = 6'd3;
                mgmt_writedata = n_word_q;
            end
            S_WR_M: begin
                mgmt_address   = 6'd4;
                mgmt_writedata = m_word_q;
            end
            S_WR_C: begin
                mgmt_address   = 6'd5;
                mgmt_writedata = c_word_q;
            end
            S_WR_START: begin
                mgmt_address   = 6'd2;
                mgmt_writedata = 32'd1;
            end
            default: begin
                mgmt_address   = 6'd0;
                mgmt_writedata = 32'd0;
            end
        endcase
    end

endmodule

// File: tb/tb_pll_retune_ctrl.sv
// Bench for pll_retune_ctrl: transaction-level model checked every cycle
// plus directed scenarios with literal expectations.
module tb_pll_retune_ctrl;

    localparam int TO   = 16;
    localparam int SYNC = 2;
    localparam int CIDX = 0;
    localparam int IGN  = 2 + SYNC;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [7:0]  req_n_hi = 8'd0, req_n_lo = 8'd0;
    logic [7:0]  req_m_hi = 8'd0, req_m_lo = 8'd0;
    logic [7:0]  req_c_hi = 8'd0, req_c_lo = 8'd0;
    logic        req_n_odd = 1'b0, req_m_odd = 1'b0, req_c_odd = 1'b0;
    logic [5:0]  mgmt_address;
    logic        mgmt_write;
    logic [31:0] mgmt_writedata;
    logic        mgmt_waitrequest = 1'b0;
    logic        pll_locked = 1'b1;
    logic        busy;
    logic        done;
    logic [1:0]  err_code;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    pll_retune_ctrl #(
        .C_INDEX(CIDX),
        .TIMEOUT_CYC(TO),
        .SYNC_STAGES(SYNC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_n_hi(req_n_hi),
        .req_n_lo(req_n_lo),
        .req_m_hi(req_m_hi),
        .req_m_lo(req_m_lo),
        .req_c_hi(req_c_hi),
        .req_c_lo(req_c_lo),
        .req_n_odd(req_n_odd),
        .req_m_odd(req_m_odd),
        .req_c_odd(req_c_odd),
        .mgmt_address(mgmt_address),
        .mgmt_write(mgmt_write),
        .mgmt_writedata(mgmt_writedata),
        .mgmt_waitrequest(mgmt_waitrequest),
        .pll_locked(pll_locked),
        .busy(busy),
        .done(done),
        .err_code(err_code)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            if (bad <= 40)
                $display("FAIL %s: got %0h want %0h (cycle %0d)",
                         nm, act, exp, cyc);
        end
    endtask

    function automatic int word(input int hi, input int lo, input int odd);
        int w;
        w = hi * 256 + lo;
        if (hi == 0 && lo == 0) w = w + 32'h10000;
        if (odd != 0) w = w + 32'h20000;
        return w;
    endfunction

    typedef struct {
        int a;
        int d;
        int c;
    } wr_t;
    wr_t wlog[$];
    int  acc_cyc[$];
    int  done_cyc[$];

    typedef enum {P_IDLE, P_WR, P_WAIT, P_FIN} ph_t;
    ph_t ph = P_IDLE;
    int  widx = 0;
    int  ent = 0;
    int  exp_err = 0;
    int  ea[5];
    int  ed[5];

    // Reference model: predicts the request/bus/lock transaction flow
    always @(negedge clk) begin
        wr_t w;
        if (rst) begin
            ph = P_IDLE;
            exp_err = 0;
        end else begin
            chk("ready", 32'(req_ready), 32'(ph == P_IDLE));
            chk("busy", 32'(busy), 32'(ph == P_WR || ph == P_WAIT));
            chk("done", 32'(done), 32'(ph == P_FIN));
            chk("err", 32'(err_code), 32'(exp_err));
            chk("mwrite", 32'(mgmt_write), 32'(ph == P_WR));
            if (ph == P_WR) begin
                chk("maddr", 32'(mgmt_address), 32'(ea[widx]));
                chk("mdata", mgmt_writedata, 32'(ed[widx]));
            end
            if (mgmt_write && !mgmt_waitrequest) begin
                w.a = int'(mgmt_address);
                w.d = int'(mgmt_writedata);
                w.c = cyc;
                wlog.push_back(w);
            end
            if (req_valid && req_ready) acc_cyc.push_back(cyc);
            if (done) done_cyc.push_back(cyc);
            case (ph)
                P_IDLE: begin
                    if (req_valid) begin
                        ea = '{0, 3, 4, 5, 2};
                        ed[0] = 0;
                        ed[1] = word(int'(req_n_hi), int'(req_n_lo), int'(req_n_odd));
                        ed[2] = word(int'(req_m_hi), int'(req_m_lo), int'(req_m_odd));
                        ed[3] = word(int'(req_c_hi), int'(req_c_lo), int'(req_c_odd))
                                + CIDX * 32'h40000;
                        ed[4] = 1;
                        ph = P_WR;
                        widx = 0;
                        ent = cyc + 1;
                        exp_err = 0;
                    end
                end
                P_WR: begin
                    if (!mgmt_waitrequest) begin
                        if (widx == 4) ph = P_WAIT;
                        else widx++;
                        ent = cyc + 1;
                    end else if (cyc - ent == TO - 1) begin
                        ph = P_FIN;
                        exp_err = 1;
                    end
                end
                P_WAIT: begin
                    if (cyc - ent >= IGN && pll_locked) begin
                        ph = P_FIN;
                        exp_err = 0;
                    end else if (cyc - ent == TO - 1) begin
                        ph = P_FIN;
                        exp_err = 2;
                    end
                end
                default: ph = P_IDLE;
            endcase
        end
    end

    task automatic set_req(input int nh, input int nl, input int no,
                           input int mh, input int ml, input int mo,
                           input int ch, input int cl, input int co);
        req_n_hi = 8'(nh); req_n_lo = 8'(nl); req_n_odd = 1'(no);
        req_m_hi = 8'(mh); req_m_lo = 8'(ml); req_m_odd = 1'(mo);
        req_c_hi = 8'(ch); req_c_lo = 8'(cl); req_c_odd = 1'(co);
    endtask

    task automatic issue(output int ca);
        bit got;
        got = 1'b0;
        ca = -1;
        req_valid = 1'b1;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            if (req_ready) begin
                got = 1'b1;
                ca = cyc;
            end
            @(posedge clk);
            #1;
        end
        req_valid = 1'b0;
        chk("accept_seen", 32'(got), 32'd1);
    endtask

    task automatic wait_done(output int dc);
        bit got;
        got = 1'b0;
        dc = -1;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            if (done) begin
                got = 1'b1;
                dc = cyc;
            end
        end
        chk("done_seen", 32'(got), 32'd1);
    endtask

    function automatic int starts();
        int n;
        n = 0;
        foreach (wlog[i]) if (wlog[i].a == 2) n++;
        return n;
    endfunction

    initial begin
        int ca, dc, held, cnt;
        int xa[5];
        int xd[5];
        bit seen;

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        chk("rst_ready", 32'(req_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err_code), 32'd0);
        chk("rst_write", 32'(mgmt_write), 32'd0);
        chk("rst_addr", 32'(mgmt_address), 32'd0);
        chk("rst_data", mgmt_writedata, 32'd0);
        @(negedge clk);
        #2 rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;

        // 1: no stalls, already locked
        set_req(0, 0, 0, 7, 6, 1, 3, 2, 1);
        wlog.delete();
        issue(ca);
        wait_done(dc);
        chk("t1_err", 32'(err_code), 32'd0);
        #1;
        chk("t1_latency", 32'(dc - ca - 1), 32'd10);
        chk("t1_nwr", 32'(wlog.size()), 32'd5);
        xa = '{0, 3, 4, 5, 2};
        xd = '{0, 32'h10000, 32'h20706, 32'h20302, 1};
        for (int i = 0; i < 5 && i < wlog.size(); i++) begin
            chk("t1_addr", 32'(wlog[i].a), 32'(xa[i]));
            chk("t1_data", 32'(wlog[i].d), 32'(xd[i]));
        end
        @(posedge clk);
        #1;

        // 2: five stall cycles on the M write
        set_req(2, 1, 0, 7, 6, 1, 0, 0, 0);
        wlog.delete();
        issue(ca);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (mgmt_write && mgmt_address == 6'd3) seen = 1'b1;
        end
        @(posedge clk);
        #1 mgmt_waitrequest = 1'b1;
        held = 0;
        repeat (5) begin
            @(negedge clk);
            if (mgmt_write && mgmt_address == 6'd4 &&
                mgmt_writedata == 32'h20706) held++;
            @(posedge clk);
            #1;
        end
        mgmt_waitrequest = 1'b0;
        @(negedge clk);
        if (mgmt_write && mgmt_address == 6'd4 &&
            mgmt_writedata == 32'h20706) held++;
        chk("t2_hold", 32'(held), 32'd6);
        wait_done(dc);
        chk("t2_err", 32'(err_code), 32'd0);
        #1;
        chk("t2_nwr", 32'(wlog.size()), 32'd5);
        if (wlog.size() == 5)
            chk("t2_mgap", 32'(wlog[2].c - wlog[1].c), 32'd6);
        @(posedge clk);
        #1;

        // 3: waitrequest stuck on the N write
        set_req(4, 4, 0, 1, 1, 0, 1, 1, 0);
        wlog.delete();
        issue(ca);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (mgmt_write && mgmt_address == 6'd0) seen = 1'b1;
        end
        @(posedge clk);
        #1 mgmt_waitrequest = 1'b1;
        cnt = 0;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
            else if (mgmt_write && mgmt_address == 6'd3) cnt++;
        end
        chk("t3_done", 32'(seen), 32'd1);
        chk("t3_nhold", 32'(cnt), 32'd16);
        chk("t3_err", 32'(err_code), 32'd1);
        chk("t3_wr_off", 32'(mgmt_write), 32'd0);
        #1;
        chk("t3_starts", 32'(starts()), 32'd0);
        @(posedge clk);
        #1 mgmt_waitrequest = 1'b0;

        // 4: lock never returns
        pll_locked = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        issue(ca);
        cnt = 0;
        seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
            else if (busy && !mgmt_write) cnt++;
        end
        chk("t4_done", 32'(seen), 32'd1);
        chk("t4_wait", 32'(cnt), 32'd16);
        chk("t4_err", 32'(err_code), 32'd2);
        @(posedge clk);
        #1 pll_locked = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("t4_errheld", 32'(err_code), 32'd2);
        @(posedge clk);
        #1;
        issue(ca);
        @(negedge clk);
        chk("t4_errclr", 32'(err_code), 32'd0);
        wait_done(dc);
        chk("t4_err_ok", 32'(err_code), 32'd0);
        @(posedge clk);
        #1;

        // 5: reset in the middle of the C write
        set_req(1, 2, 0, 3, 4, 0, 5, 6, 1);
        wlog.delete();
        issue(ca);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (mgmt_write && mgmt_address == 6'd5) seen = 1'b1;
        end
        chk("t5_reach_c", 32'(seen), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("t5_write", 32'(mgmt_write), 32'd0);
        chk("t5_busy", 32'(busy), 32'd0);
        chk("t5_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("t5_starts", 32'(starts()), 32'd0);
        @(posedge clk);
        #1;
        wlog.delete();
        issue(ca);
        wait_done(dc);
        #1;
        chk("t5_rerun_nwr", 32'(wlog.size()), 32'd5);
        chk("t5_rerun_start", 32'(starts()), 32'd1);
        @(posedge clk);
        #1;

        // 6: req_valid held through two runs
        set_req(0, 0, 1, 9, 9, 0, 2, 2, 0);
        wlog.delete();
        acc_cyc.delete();
        done_cyc.delete();
        req_valid = 1'b1;
        cnt = 0;
        for (int i = 0; i < 100 && cnt < 2; i++) begin
            @(negedge clk);
            if (done) cnt++;
        end
        @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("t6_dones", 32'(done_cyc.size()), 32'd2);
        chk("t6_accepts", 32'(acc_cyc.size()), 32'd2);
        chk("t6_starts", 32'(starts()), 32'd2);
        if (acc_cyc.size() == 2 && done_cyc.size() == 2)
            chk("t6_reaccept", 32'(acc_cyc[1] - done_cyc[0]), 32'd1);

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: bench did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

endmodule
